// File: rtl/data_tag_valid_ram_if.sv
// Processor-side port bundle of the direct-mapped cache storage arrays.
// The master drives address, data and requests; the slave returns the lookup.
interface data_tag_valid_ram_if #(
    parameter int MEMORY_BITS = 5,
    parameter int INDEX       = 3,
    parameter int DATA_WIDTH  = 32
);
    localparam int TAG_BITS = MEMORY_BITS - INDEX;

    logic [MEMORY_BITS-1:0] fulladdress;
    logic [DATA_WIDTH-1:0]  write_data;
    logic [DATA_WIDTH-1:0]  fill_data;
    logic                   write_signal;
    logic                   read_signal;
    logic                   valid_out;
    logic [TAG_BITS-1:0]    tag_out;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   match;

    modport master (
        output fulladdress, write_data, fill_data, write_signal, read_signal,
        input  valid_out, tag_out, data_out, match
    );

    modport slave (
        input  fulladdress, write_data, fill_data, write_signal, read_signal,
        output valid_out, tag_out, data_out, match
    );
endinterface

// File: rtl/data_tag_valid_ram.sv
// Valid/tag/data arrays of a direct-mapped cache with combinational lookup,
// write-through allocate on stores and line fill on read misses.
module data_tag_valid_ram #(
    parameter int MEMORY_BITS = 5,
    parameter int INDEX       = 3,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    data_tag_valid_ram_if.slave   bus
);
    localparam int TAG_BITS = MEMORY_BITS - INDEX;
    localparam int LINES    = 2 ** INDEX;

    logic [LINES-1:0]      valid_r;
    logic [TAG_BITS-1:0]   tag_r  [LINES];
    logic [DATA_WIDTH-1:0] data_r [LINES];

    logic [INDEX-1:0]      index_s;
    logic [TAG_BITS-1:0]   addr_tag_s;
    logic                  line_valid_s;
    logic [TAG_BITS-1:0]   line_tag_s;
    logic [DATA_WIDTH-1:0] line_data_s;
    logic                  match_s;
    logic                  upd_en_s;
    logic [DATA_WIDTH-1:0] upd_data_s;

    // Address split and lookup of the indexed line.
    always_comb begin
        index_s      = bus.fulladdress[INDEX-1:0];
        addr_tag_s   = bus.fulladdress[MEMORY_BITS-1:INDEX];
        line_valid_s = valid_r[index_s];
        line_tag_s   = tag_r[index_s];
        line_data_s  = data_r[index_s];
        match_s      = bus.read_signal & line_valid_s & (line_tag_s == addr_tag_s);
    end

    // Update selection: a store always wins; otherwise a read miss fills the line.
    always_comb begin
        upd_en_s   = 1'b0;
        upd_data_s = '0;
        if (bus.write_signal) begin
            upd_en_s   = 1'b1;
            upd_data_s = bus.write_data;
        end else if (bus.read_signal && !match_s) begin
            upd_en_s   = 1'b1;
            upd_data_s = bus.fill_data;
        end else begin
            upd_en_s   = 1'b0;
            upd_data_s = '0;
        end
    end

    // Drive the lookup result onto the bus.
    always_comb begin
        bus.valid_out = line_valid_s;
        bus.tag_out   = line_tag_s;
        bus.data_out  = line_data_s;
        bus.match     = match_s;
    end

    // Array storage; reset clears every line and outranks any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= '0;
                data_r[i]  <= '0;
            end
        end else if (upd_en_s) begin
            valid_r[index_s] <= 1'b1;
            tag_r[index_s]   <= addr_tag_s;
            data_r[index_s]  <= upd_data_s;
        end
    end
endmodule

// File: tb/tb_data_tag_valid_ram.sv
// Self-checking bench: a cache-line model checked against the DUT every cycle,
// plus directed scenarios with literal expectations.
module tb_data_tag_valid_ram;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   started;

    data_tag_valid_ram_if #(.MEMORY_BITS(5), .INDEX(3), .DATA_WIDTH(32)) bus ();

    data_tag_valid_ram #(.MEMORY_BITS(5), .INDEX(3), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Model: one record per cache line
    typedef struct {
        bit          v;
        bit [1:0]    t;
        bit [31:0]   d;
    } line_t;
    line_t lines [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [4:0] a, input logic rd);
        line_t l;
        l = lines[int'(a[2:0])];
        return rd && l.v && (l.t == a[4:3]);
    endfunction

    // Model state update on each rising edge
    always @(posedge clk) begin
        int idx;
        idx = int'(bus.fulladdress[2:0]);
        if (reset) begin
            foreach (lines[i]) lines[i] = '{v: 1'b0, t: 2'd0, d: 32'd0};
            started = 1'b1;
        end else if (bus.write_signal) begin
            lines[idx] = '{v: 1'b1, t: bus.fulladdress[4:3], d: bus.write_data};
        end else if (bus.read_signal && !model_hit(bus.fulladdress, bus.read_signal)) begin
            lines[idx] = '{v: 1'b1, t: bus.fulladdress[4:3], d: bus.fill_data};
        end
    end

    // Per-cycle comparison, mid low phase with inputs stable
    always @(negedge clk) begin
        #2;
        if (started) begin
            line_t l;
            l = lines[int'(bus.fulladdress[2:0])];
            chk("cyc_valid", {31'd0, bus.valid_out}, {31'd0, l.v});
            chk("cyc_tag",   {30'd0, bus.tag_out},   {30'd0, l.t});
            chk("cyc_data",  bus.data_out,           l.d);
            chk("cyc_match", {31'd0, bus.match},
                {31'd0, model_hit(bus.fulladdress, bus.read_signal)});
        end
    end

    task automatic step(input logic rst, input logic [4:0] a, input logic wr, input logic [31:0] wd,
                        input logic rd, input logic [31:0] fd);
        @(negedge clk);
        reset            = rst;
        bus.fulladdress  = a;
        bus.write_signal = wr;
        bus.write_data   = wd;
        bus.read_signal  = rd;
        bus.fill_data    = fd;
        #3;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        reset            = 1'b1;
        bus.fulladdress  = 5'd0;
        bus.write_signal = 1'b0;
        bus.write_data   = 32'd0;
        bus.read_signal  = 1'b0;
        bus.fill_data    = 32'd0;

        step(1'b1, 5'h00, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 5'h03, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("rst_match", {31'd0, bus.match},     32'd0);
        chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_data",  bus.data_out,           32'd0);

        step(1'b0, 5'h0B, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0);
        step(1'b0, 5'h0B, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("wr_hit_match", {31'd0, bus.match},   32'd1);
        chk("wr_hit_data",  bus.data_out,         32'hDEADBEEF);
        chk("wr_hit_tag",   {30'd0, bus.tag_out}, 32'd1);

        step(1'b0, 5'h03, 1'b0, 32'd0, 1'b1, 32'h1234);
        chk("conflict_miss", {31'd0, bus.match}, 32'd0);
        step(1'b0, 5'h03, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("fill_hit_match", {31'd0, bus.match}, 32'd1);
        chk("fill_hit_data",  bus.data_out,       32'h1234);
        step(1'b0, 5'h0B, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("evicted_miss", {31'd0, bus.match}, 32'd0);

        step(1'b0, 5'h1F, 1'b1, 32'h5, 1'b1, 32'hA5A5A5A5);
        step(1'b0, 5'h1F, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("wr_prio_match", {31'd0, bus.match},   32'd1);
        chk("wr_prio_data",  bus.data_out,         32'h5);
        chk("wr_prio_tag",   {30'd0, bus.tag_out}, 32'd3);

        for (int i = 0; i < 8; i++) begin
            logic [4:0] a;
            a = 5'(i) | 5'h10;
            step(1'b0, a, 1'b1, 32'h100 + 32'(i), 1'b0, 32'd0);
        end
        step(1'b0, 5'h16, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("full_hit_data", bus.data_out, 32'h106);
        step(1'b1, 5'h00, 1'b1, 32'hFFFF, 1'b1, 32'hEEEE);
        for (int i = 0; i < 8; i++) begin
            logic [4:0] a;
            a = 5'(i) | 5'h10;
            step(1'b0, a, 1'b0, 32'd0, 1'b1, 32'd0);
            chk("clr_valid", {31'd0, bus.valid_out}, 32'd0);
            chk("clr_match", {31'd0, bus.match},     32'd0);
        end

        step(1'b0, 5'h15, 1'b1, 32'hCAFE, 1'b0, 32'd0);
        step(1'b0, 5'h15, 1'b0, 32'd0, 1'b0, 32'h9999);
        chk("nord_match", {31'd0, bus.match},     32'd0);
        chk("nord_valid", {31'd0, bus.valid_out}, 32'd1);
        step(1'b0, 5'h15, 1'b0, 32'd0, 1'b0, 32'h9999);
        chk("idle_data", bus.data_out, 32'hCAFE);
        step(1'b0, 5'h15, 1'b0, 32'd0, 1'b1, 32'h9999);
        chk("idle_hit", {31'd0, bus.match}, 32'd1);

        step(1'b0, 5'h00, 1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
